// File: rtl/alu_op_scheduler_if.sv
// Handshake and ALU-side bundle for alu_op_scheduler.
// slave is the scheduler's view; master is the requester/consumer/ALU environment.
interface alu_op_scheduler_if #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) ();
    localparam int CW = $clog2(DEPTH) + 1;

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic [3:0]       in_con;
    logic             in_chain;

    logic [WIDTH-1:0] alu_a;
    logic [WIDTH-1:0] alu_b;
    logic [3:0]       alu_con;
    logic [WIDTH-1:0] alu_res;
    logic             alu_neg;
    logic             alu_carry;
    logic             alu_overflow;
    logic             alu_zero;

    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_res;
    logic [3:0]       out_flags;
    logic [CW-1:0]    count;
    logic             busy;

    modport slave (
        input  in_valid, in_a, in_b, in_con, in_chain,
        output in_ready,
        output alu_a, alu_b, alu_con,
        input  alu_res, alu_neg, alu_carry, alu_overflow, alu_zero,
        output out_valid, out_res, out_flags,
        input  out_ready,
        output count, busy
    );

    modport master (
        output in_valid, in_a, in_b, in_con, in_chain,
        input  in_ready,
        input  alu_a, alu_b, alu_con,
        output alu_res, alu_neg, alu_carry, alu_overflow, alu_zero,
        input  out_valid, out_res, out_flags,
        output out_ready,
        input  count, busy
    );
endinterface

// File: rtl/alu_op_scheduler.sv
// Request FIFO -> S1 issue register -> external ALU -> S2 result register,
// with optional chaining of the previous result as operand A.
module alu_op_scheduler #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    alu_op_scheduler_if.slave sched
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] fifo_a_q     [DEPTH];
    logic [WIDTH-1:0] fifo_b_q     [DEPTH];
    logic [3:0]       fifo_con_q   [DEPTH];
    logic             fifo_chain_q [DEPTH];

    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;

    logic             s1_valid_q, s1_valid_d;
    logic [WIDTH-1:0] s1_a_q, s1_a_d;
    logic [WIDTH-1:0] s1_b_q, s1_b_d;
    logic [3:0]       s1_con_q, s1_con_d;

    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_res_q, out_res_d;
    logic [3:0]       out_flags_q, out_flags_d;
    logic [WIDTH-1:0] acc_q, acc_d;

    logic             push, s1_load, s2_load, fifo_empty, head_chain;

    assign fifo_empty = (count_q == '0);
    assign head_chain = fifo_chain_q[rd_ptr_q];
    assign push       = sched.in_valid & (count_q != CW'(DEPTH));
    assign s2_load    = s1_valid_q & (~out_valid_q | sched.out_ready);
    // A chained head waits for S1 to be fully empty so acc already holds its predecessor's result.
    assign s1_load    = ~fifo_empty & (~s1_valid_q | (s2_load & ~head_chain));

    always_comb begin
        count_d = count_q;
        case ({push, s1_load})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
        wr_ptr_d = push    ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = s1_load ? rd_ptr_q + AW'(1) : rd_ptr_q;

        s1_valid_d = s1_load | (s1_valid_q & ~s2_load);
        s1_a_d     = s1_a_q;
        s1_b_d     = s1_b_q;
        s1_con_d   = s1_con_q;
        if (s1_load) begin
            s1_a_d   = head_chain ? acc_q : fifo_a_q[rd_ptr_q];
            s1_b_d   = fifo_b_q[rd_ptr_q];
            s1_con_d = fifo_con_q[rd_ptr_q];
        end

        out_valid_d = out_valid_q;
        out_res_d   = out_res_q;
        out_flags_d = out_flags_q;
        acc_d       = acc_q;
        if (s2_load) begin
            out_valid_d = 1'b1;
            out_res_d   = sched.alu_res;
            out_flags_d = {sched.alu_neg, sched.alu_carry, sched.alu_overflow, sched.alu_zero};
            acc_d       = sched.alu_res;
        end else if (sched.out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_a_q[wr_ptr_q]     <= sched.in_a;
            fifo_b_q[wr_ptr_q]     <= sched.in_b;
            fifo_con_q[wr_ptr_q]   <= sched.in_con;
            fifo_chain_q[wr_ptr_q] <= sched.in_chain;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            s1_valid_q  <= 1'b0;
            s1_a_q      <= '0;
            s1_b_q      <= '0;
            s1_con_q    <= '0;
            out_valid_q <= 1'b0;
            out_res_q   <= '0;
            out_flags_q <= '0;
            acc_q       <= '0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            s1_valid_q  <= s1_valid_d;
            s1_a_q      <= s1_a_d;
            s1_b_q      <= s1_b_d;
            s1_con_q    <= s1_con_d;
            out_valid_q <= out_valid_d;
            out_res_q   <= out_res_d;
            out_flags_q <= out_flags_d;
            acc_q       <= acc_d;
        end
    end

    assign sched.in_ready  = (count_q != CW'(DEPTH));
    assign sched.alu_a     = s1_valid_q ? s1_a_q   : '0;
    assign sched.alu_b     = s1_valid_q ? s1_b_q   : '0;
    assign sched.alu_con   = s1_valid_q ? s1_con_q : '0;
    assign sched.out_valid = out_valid_q;
    assign sched.out_res   = out_res_q;
    assign sched.out_flags = out_flags_q;
    assign sched.count     = count_q;
    assign sched.busy      = ~fifo_empty | s1_valid_q | out_valid_q;
endmodule

// File: tb/tb_alu_op_scheduler.sv
// Directed bench for alu_op_scheduler with an in-order result scoreboard and an ALU model.
module tb_alu_op_scheduler;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    alu_op_scheduler_if #(.WIDTH(32), .DEPTH(4)) bus ();

    alu_op_scheduler #(.WIDTH(32), .DEPTH(4)) dut (
        .clk   (clk),
        .rst   (rst),
        .sched (bus)
    );

    int checks    = 0;
    int failures  = 0;
    int delivered = 0;
    bit armed     = 1'b0;

    // Returns {neg, carry, overflow, zero, res}.
    function automatic logic [35:0] alu_fn(input logic [31:0] a, input logic [31:0] b,
                                           input logic [3:0] con);
        logic [32:0] w;
        logic [31:0] r;
        logic        c, v;
        w = '0; r = a; c = 1'b0; v = 1'b0;
        case (con)
            4'h0: begin
                w = {1'b0, a} + {1'b0, b}; r = w[31:0]; c = w[32];
                v = (a[31] == b[31]) && (r[31] != a[31]);
            end
            4'h1: begin
                w = {1'b0, a} - {1'b0, b}; r = w[31:0]; c = ~w[32];
                v = (a[31] != b[31]) && (r[31] != a[31]);
            end
            4'h2:    r = a & b;
            4'h3:    r = a | b;
            4'h4:    r = a ^ b;
            default: r = a;
        endcase
        return {r[31], c, v, (r == 32'h0), r};
    endfunction

    logic [35:0] alu_out;
    assign alu_out          = alu_fn(bus.alu_a, bus.alu_b, bus.alu_con);
    assign bus.alu_res      = alu_out[31:0];
    assign bus.alu_zero     = alu_out[32];
    assign bus.alu_overflow = alu_out[33];
    assign bus.alu_carry    = alu_out[34];
    assign bus.alu_neg      = alu_out[35];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    task automatic timeout_fail(input string name);
        checks++;
        failures++;
        $display("FAIL %s got=timeout exp=event", name);
    endtask

    // Scoreboard: every accepted op's expected result in acceptance order.
    // acc is simply the result of the most recently accepted op.
    logic [35:0] exp_q[$];
    logic [31:0] acc_m = '0;

    always @(negedge clk) begin
        logic [31:0] a_eff;
        logic [35:0] r;
        if (armed) begin
            chk("busy", {31'b0, bus.busy}, {31'b0, exp_q.size() != 0});
            if (bus.out_valid) begin
                if (exp_q.size() == 0) begin
                    chk("out_unexpected", {31'b0, bus.out_valid}, 32'h0);
                end else begin
                    chk("out_res", bus.out_res, exp_q[0][31:0]);
                    chk("out_flags", {28'b0, bus.out_flags}, {28'b0, exp_q[0][35:32]});
                end
            end
            if (rst) begin
                exp_q.delete();
                acc_m = '0;
            end else begin
                if (bus.out_valid && bus.out_ready && exp_q.size() != 0) begin
                    void'(exp_q.pop_front());
                    delivered++;
                end
                if (bus.in_valid && bus.in_ready) begin
                    a_eff = bus.in_chain ? acc_m : bus.in_a;
                    r = alu_fn(a_eff, bus.in_b, bus.in_con);
                    exp_q.push_back(r);
                    acc_m = r[31:0];
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [31:0] a, input logic [31:0] b, input logic [3:0] con,
                        input logic ch);
        logic ok;
        ok = 1'b0;
        bus.in_valid = 1'b1; bus.in_a = a; bus.in_b = b; bus.in_con = con; bus.in_chain = ch;
        for (int n = 0; n < 40 && !ok; n++) begin
            @(negedge clk);
            ok = bus.in_ready;
            step();
        end
        bus.in_valid = 1'b0;
        if (!ok) timeout_fail("send_timeout");
    endtask

    task automatic get_out(output logic [31:0] res, output logic [3:0] flags);
        logic found;
        found = 1'b0; res = '0; flags = '0;
        for (int n = 0; n < 40 && !found; n++) begin
            @(negedge clk);
            if (bus.out_valid) begin
                found = 1'b1; res = bus.out_res; flags = bus.out_flags;
            end
        end
        step();
        if (!found) timeout_fail("get_out_timeout");
    endtask

    task automatic drain();
        logic idle;
        idle = 1'b0;
        bus.out_ready = 1'b1;
        for (int n = 0; n < 60 && !idle; n++) begin
            @(negedge clk);
            idle = !bus.busy;
        end
        step();
        if (!idle) timeout_fail("drain_timeout");
    endtask

    initial begin
        logic [31:0] r;
        logic [3:0]  f;
        logic        rdy;
        int          acc_cnt;
        int          d0;
        logic        exp_rdy [7];

        rst = 1'b1;
        bus.in_valid = 1'b0; bus.in_a = '0; bus.in_b = '0; bus.in_con = '0; bus.in_chain = 1'b0;
        bus.out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        armed = 1'b1;

        @(negedge clk);
        chk("rst_out_valid", {31'b0, bus.out_valid}, 32'h0);
        chk("rst_count", {29'b0, bus.count}, 32'h0);
        chk("rst_in_ready", {31'b0, bus.in_ready}, 32'h1);
        chk("rst_busy", {31'b0, bus.busy}, 32'h0);
        chk("rst_out_res", bus.out_res, 32'h0);
        chk("rst_out_flags", {28'b0, bus.out_flags}, 32'h0);
        chk("rst_alu_a", bus.alu_a, 32'h0);
        chk("rst_alu_b", bus.alu_b, 32'h0);
        chk("rst_alu_con", {28'b0, bus.alu_con}, 32'h0);
        step();

        // Single op latency
        send(32'h5, 32'h3, 4'h0, 1'b0);
        @(negedge clk); chk("t1_ov_e0", {31'b0, bus.out_valid}, 32'h0);
        step();
        @(negedge clk); chk("t1_ov_e1", {31'b0, bus.out_valid}, 32'h0);
        step();
        @(negedge clk);
        chk("t1_ov_e2", {31'b0, bus.out_valid}, 32'h1);
        chk("t1_res", bus.out_res, 32'h8);
        chk("t1_flags", {28'b0, bus.out_flags}, 32'h0);
        step();
        @(negedge clk);
        chk("t1_busy_after", {31'b0, bus.busy}, 32'h0);
        step();

        // Chaining with one-cycle bubble
        send(32'h5, 32'h3, 4'h0, 1'b0);
        send(32'hDEAD, 32'h2, 4'h0, 1'b1);
        @(negedge clk);
        chk("t2_alu_a_op1", bus.alu_a, 32'h5);
        chk("t2_alu_b_op1", bus.alu_b, 32'h3);
        step();
        @(negedge clk);
        chk("t2_ov_first", {31'b0, bus.out_valid}, 32'h1);
        chk("t2_res_first", bus.out_res, 32'h8);
        chk("t2_bubble_alu_a", bus.alu_a, 32'h0);
        step();
        @(negedge clk);
        chk("t2_ov_gap", {31'b0, bus.out_valid}, 32'h0);
        chk("t2_alu_a_chain", bus.alu_a, 32'h8);
        chk("t2_alu_b_chain", bus.alu_b, 32'h2);
        step();
        @(negedge clk);
        chk("t2_ov_second", {31'b0, bus.out_valid}, 32'h1);
        chk("t2_res_second", bus.out_res, 32'hA);
        drain();

        // Backpressure: 7 pushes, 6 accepted
        exp_rdy = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        bus.out_ready = 1'b0;
        acc_cnt = 0;
        d0 = delivered;
        for (int i = 0; i < 7; i++) begin
            bus.in_valid = 1'b1; bus.in_a = i; bus.in_b = '0; bus.in_con = 4'h0; bus.in_chain = 1'b0;
            @(negedge clk);
            rdy = bus.in_ready;
            chk("t3_in_ready", {31'b0, rdy}, {31'b0, exp_rdy[i]});
            if (rdy) acc_cnt++;
            step();
        end
        bus.in_valid = 1'b0;
        chk("t3_accepted", acc_cnt, 32'd6);
        @(negedge clk);
        chk("t3_count_full", {29'b0, bus.count}, 32'd4);
        chk("t3_in_ready_full", {31'b0, bus.in_ready}, 32'h0);
        chk("t3_held_res", bus.out_res, 32'h0);
        step();
        drain();
        chk("t3_delivered", delivered - d0, 32'd6);
        chk("t3_sb_empty", exp_q.size(), 32'd0);

        // Flags
        send(32'h7FFFFFFF, 32'h7FFFFFFF, 4'h0, 1'b0);
        send(32'hFFFFFFF8, 32'h8, 4'h0, 1'b0);
        get_out(r, f);
        chk("t4_res_ovf", r, 32'hFFFFFFFE);
        chk("t4_flags_ovf", {28'b0, f}, 32'b1010);
        get_out(r, f);
        chk("t4_res_zero", r, 32'h0);
        chk("t4_flags_zero", {28'b0, f}, 32'b0101);
        drain();

        // Reset mid-operation
        bus.out_ready = 1'b0;
        send(32'h1, 32'h1, 4'h0, 1'b0);
        send(32'h2, 32'h2, 4'h0, 1'b0);
        send(32'h3, 32'h3, 4'h0, 1'b0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        @(negedge clk);
        chk("t5_out_valid", {31'b0, bus.out_valid}, 32'h0);
        chk("t5_count", {29'b0, bus.count}, 32'h0);
        chk("t5_in_ready", {31'b0, bus.in_ready}, 32'h1);
        chk("t5_busy", {31'b0, bus.busy}, 32'h0);
        chk("t5_out_res", bus.out_res, 32'h0);
        step();
        bus.out_ready = 1'b1;
        send(32'hFFFF, 32'h4, 4'h0, 1'b1);
        get_out(r, f);
        chk("t5_chain_after_rst", r, 32'h4);
        drain();

        // Full boundary: push rejected in the cycle a pop happens
        bus.out_ready = 1'b0;
        for (int i = 0; i < 6; i++) send(32'h100 + i, 32'h1, 4'h0, 1'b0);
        bus.in_valid = 1'b1; bus.in_a = 32'h200; bus.in_b = 32'h7; bus.in_con = 4'h0; bus.in_chain = 1'b0;
        bus.out_ready = 1'b1;
        @(negedge clk);
        chk("t6_count_full", {29'b0, bus.count}, 32'd4);
        chk("t6_in_ready_full", {31'b0, bus.in_ready}, 32'h0);
        step();
        @(negedge clk);
        chk("t6_count_after_pop", {29'b0, bus.count}, 32'd3);
        chk("t6_in_ready_after", {31'b0, bus.in_ready}, 32'h1);
        step();
        bus.in_valid = 1'b0;
        @(negedge clk);
        chk("t6_count_push_pop", {29'b0, bus.count}, 32'd3);
        step();
        drain();

        // Mixed opcodes and chains, first under backpressure then free-running
        bus.out_ready = 1'b0;
        send(32'd100, 32'd23, 4'h0, 1'b0);
        send(32'h0, 32'd3, 4'h1, 1'b1);
        send(32'hF0F0, 32'hFF, 4'h4, 1'b0);
        send(32'h0, 32'h100, 4'h3, 1'b1);
        send(32'h0, 32'hFFFFFFFF, 4'h0, 1'b1);
        drain();
        send(32'hFF00FF00, 32'h0FF00FF0, 4'h2, 1'b0);
        send(32'h0, 32'h1, 4'h0, 1'b1);
        send(32'd3, 32'd5, 4'h1, 1'b0);
        send(32'h0, 32'd2, 4'h0, 1'b1);
        send(32'h0, 32'h0, 4'h2, 1'b1);
        drain();
        chk("mix_sb_empty", exp_q.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end
endmodule

// File: doc/alu_op_scheduler.md
Name: alu_op_scheduler

Overview:
- Front-end sequencer for the team's 32-bit combinational ALU (ports A, B, con[3:0] -> res, neg, carry, overflow, zero).
- Accepts operation requests through a valid/ready handshake and buffers them in a DEPTH-entry FIFO.
- Issues one operation per cycle to the ALU, registers the result and flags, and returns them in order under backpressure.
- Supports chaining: an operation can use the previous result as operand A.

Parameters:
- WIDTH, 32, operand/result width; must match the ALU.
- DEPTH, 4, request FIFO entries; power of two, >= 2.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- in_valid  in  1  request valid
- in_ready  out  1  request accepted when in_valid & in_ready at a clk edge
- in_a  in  WIDTH  operand A; ignored when in_chain=1
- in_b  in  WIDTH  operand B
- in_con  in  4  ALU opcode, passed through unmodified
- in_chain  in  1  use accumulator (last completed result) as A
- alu_a  out  WIDTH  to ALU A
- alu_b  out  WIDTH  to ALU B
- alu_con  out  4  to ALU con
- alu_res  in  WIDTH  from ALU res
- alu_neg, alu_carry, alu_overflow, alu_zero  in  1 each  ALU flags
- out_valid  out  1  result valid
- out_ready  in  1  consumer ready
- out_res  out  WIDTH  result
- out_flags  out  4  {neg, carry, overflow, zero}
- count  out  clog2(DEPTH)+1  FIFO occupancy
- busy  out  1  FIFO non-empty | S1 valid | out_valid

Behaviour:
- Pipeline: FIFO -> S1 issue register (a, b, con) -> S2 output register (res, flags). The ALU sits combinationally between S1 and S2.
- in_ready = (count != DEPTH), registered-count based. There is no bypass when full: a push while full is not accepted, even if a pop occurs in the same cycle.
- Push and pop in the same cycle leave count unchanged. Pointers wrap modulo DEPTH.
- S2 load: when S1 valid and (!out_valid | out_ready).
  - Captures alu_res and flags into out_res/out_flags.
  - Updates acc <= alu_res.
  - S1 drains.
- S2 drain: out_valid & out_ready with no new load clears out_valid.
- S1 load: FIFO non-empty and S1 empty, or S1 draining this cycle.
  - Pops the FIFO head.
  - If the head has chain=1, S1 loads only when S1 is empty (not when draining). This gives a one-cycle bubble so acc holds the predecessor's result. S1.a = acc at load.
- alu_a/alu_b/alu_con = S1 registers when S1 valid, otherwise 0.
- Latency with an empty pipeline and out_ready=1: request accepted at edge e0, S1 loaded at e1, out_valid high after e2 (2 cycles).
- Throughput: 1 op/cycle for unchained ops. Back-to-back chained ops run at 1 op/2 cycles.
- Ordering: results leave strictly in acceptance order. Total capacity is DEPTH+2 ops.
- Backpressure: out_valid & !out_ready holds out_res/out_flags stable. S1 holds, the FIFO fills, and in_ready deasserts at count==DEPTH.
- acc = 0 after reset. A chained op with no prior result uses A=0.
- Reset: synchronous; it discards all in-flight ops. After reset:
  - FIFO pointers and count = 0
  - S1 and S2 invalid
  - out_valid = 0, out_res = 0, out_flags = 0
  - acc = 0
  - alu_a, alu_b, alu_con = 0
  - in_ready = 1, busy = 0
- rst has priority over any same-cycle handshake.

Test Plan:
1. Single op: A=32'h5, B=32'h3, con=4'b0000 (ADD), out_ready=1 -> out_valid exactly 2 cycles after the accept edge, out_res=32'h8, out_flags=4'b0000, busy low the following cycle.
2. Chaining: ADD A=5,B=3 then chained ADD B=2 on consecutive cycles -> results 8 then 32'hA. The second out_valid comes 2 cycles after the first (one bubble). alu_a=8 is observed for the second op.
3. Backpressure (DEPTH=4): out_ready=0, push 7 ADDs with A=i,B=0 -> 6 accepted, in_ready low at count==4. Then out_ready=1 -> results 0..5 in order, with no duplicate or drop.
4. Flags: ADD A=32'h7FFFFFFF, B=32'h7FFFFFFF with ALU model -> out_res=32'hFFFFFFFE, out_flags={neg=1,carry=0,overflow=1,zero=0}. ADD A=32'hFFFFFFF8, B=32'h8 -> out_res=0, zero=1, carry=1.
5. Reset mid-op: 3 ops queued, out_ready=0, rst for 1 cycle -> next cycle out_valid=0, count=0, in_ready=1, busy=0. Then chained ADD B=4 -> out_res=32'h4.
6. Full boundary: with count==DEPTH, in_valid=1 and a pop in the same cycle -> request not accepted, count becomes DEPTH-1, and the request is accepted on the next edge.
